// File: rtl/sliding_window_buffer_if.sv
// Block-transfer bundle between the framing stage, the sliding window buffer
// and the correlation datapath: write/read handshakes, block data and status.
interface sliding_window_buffer_if #(
  parameter int P       = 4,
  parameter int NP      = 10,
  parameter int NB_DATA = 32
);
  localparam int CW = $clog2(P) + 1;

  logic                         i_wvalid;
  logic                         o_wready;
  logic [NP-1:0][NB_DATA-1:0]   i_data;
  logic                         o_rvalid;
  logic                         i_rready;
  logic [NP-1:0][NB_DATA-1:0]   o_data;
  logic [CW-1:0]                o_count;
  logic                         o_full;
  logic                         o_empty;
  logic                         o_overflow;

  modport slave (
    input  i_wvalid, i_data, i_rready,
    output o_wready, o_rvalid, o_data, o_count, o_full, o_empty, o_overflow
  );

  modport master (
    output i_wvalid, i_data, i_rready,
    input  o_wready, o_rvalid, o_data, o_count, o_full, o_empty, o_overflow
  );
endinterface

// File: rtl/sliding_window_buffer.sv
// Circular P-slot block buffer with internal wrap-around pointers, valid/ready
// on both sides, a first-word-fall-through output register and sync flush.
module sliding_window_buffer #(
  parameter int P       = 4,
  parameter int NP      = 10,
  parameter int NB_DATA = 32
) (
  input  logic                      clock,
  input  logic                      i_reset_n,
  input  logic                      i_enable,
  input  logic                      i_flush,
  sliding_window_buffer_if.slave    bus
);
  localparam int AW = $clog2(P);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(P);

  typedef logic [NP-1:0][NB_DATA-1:0] block_t;

  block_t          mem_q [P];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            out_valid_q, out_valid_d;
  block_t          data_q, data_d;
  logic            overflow_q, overflow_d;

  logic            full_s;
  logic            wready_s;
  logic            rvalid_s;
  logic            wr_xfer_s;
  logic            rd_xfer_s;
  logic            flush_s;
  logic            mem_we_s;
  logic            load_s;
  logic [CW-1:0]   pending_s;

  // Handshake decode from registered state and i_enable only.
  always_comb begin
    full_s    = (count_q == CNT_MAX);
    wready_s  = i_enable & ~full_s;
    rvalid_s  = i_enable & out_valid_q;
    flush_s   = i_enable & i_flush;
    wr_xfer_s = i_enable & bus.i_wvalid & wready_s;
    rd_xfer_s = rvalid_s & bus.i_rready;
    mem_we_s  = wr_xfer_s & ~i_flush;
    // Blocks stored but not yet moved into the output register; the one held
    // there still owns its slot until consumed.
    pending_s = count_q - {{(CW-1){1'b0}}, out_valid_q};
    load_s    = i_enable & ~i_flush & (~out_valid_q | rd_xfer_s)
                & (pending_s != {CW{1'b0}});
  end

  // Next-state for pointers, occupancy, output register and overflow flag.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    data_d      = data_q;
    overflow_d  = overflow_q;
    if (flush_s) begin
      wr_ptr_d    = {AW{1'b0}};
      rd_ptr_d    = {AW{1'b0}};
      count_d     = {CW{1'b0}};
      out_valid_d = 1'b0;
      overflow_d  = 1'b0;
    end else if (i_enable) begin
      overflow_d = bus.i_wvalid & full_s;
      if (wr_xfer_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      case ({wr_xfer_s, rd_xfer_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (load_s) begin
        data_d      = mem_q[rd_ptr_q];
        rd_ptr_d    = rd_ptr_q + PTR_ONE;
        out_valid_d = 1'b1;
      end else if (rd_xfer_s) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {CW{1'b0}};
      out_valid_q <= 1'b0;
      data_q      <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      overflow_q  <= overflow_d;
    end
  end

  // Block storage is left unreset so it maps onto plain RAM.
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem_q[wr_ptr_q] <= bus.i_data;
    end
  end

  assign bus.o_wready   = wready_s;
  assign bus.o_rvalid   = rvalid_s;
  assign bus.o_data     = data_q;
  assign bus.o_count    = count_q;
  assign bus.o_full     = full_s;
  assign bus.o_empty    = (count_q == {CW{1'b0}});
  assign bus.o_overflow = overflow_q;
endmodule

// File: tb/tb_sliding_window_buffer.sv
// Directed bench for sliding_window_buffer (P=4, NP=10, NB_DATA=32).
module tb_sliding_window_buffer;
  typedef logic [9:0][31:0] blk_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic flush = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  sliding_window_buffer_if #(.P(4), .NP(10), .NB_DATA(32)) bus ();

  sliding_window_buffer #(.P(4), .NP(10), .NB_DATA(32)) dut (
    .clock(clk), .i_reset_n(rst_n), .i_enable(en), .i_flush(flush), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic blk_t mk(input int base);
    blk_t b;
    for (int i = 0; i < 10; i++) b[i] = 32'(base + i);
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string nm, input logic [2:0] cnt, input logic rv);
    // status snapshot after an edge: count, rvalid, full and empty
    n_vec++;
    if (bus.o_count !== cnt || bus.o_rvalid !== rv ||
        bus.o_full !== (cnt == 3'd4) || bus.o_empty !== (cnt == 3'd0)) begin
      n_err++;
      $display("FAIL %s: count=%0d rvalid=%b full=%b empty=%b, required count=%0d rvalid=%b",
               nm, bus.o_count, bus.o_rvalid, bus.o_full, bus.o_empty, cnt, rv);
    end
  endtask

  task automatic write_blocks(input int base, input int n);
    for (int k = 0; k < n; k++) begin
      bus.i_data = mk(base + 16 * k);
      bus.i_wvalid = 1'b1;
      step();
    end
    bus.i_wvalid = 1'b0;
  endtask

  task automatic drain(input string nm, input int base, input int n);
    bus.i_rready = 1'b1;
    for (int k = 0; k < n; k++) begin
      n_vec++;
      if (bus.o_rvalid !== 1'b1 || bus.o_data !== mk(base + 16 * k)) begin
        n_err++;
        $display("FAIL %s[%0d]: rvalid=%b data[0]=%0d, required rvalid=1 data[0]=%0d",
                 nm, k, bus.o_rvalid, bus.o_data[0], base + 16 * k);
      end
      step();
    end
    bus.i_rready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1;
    bus.i_wvalid = 1'b0; bus.i_rready = 1'b0; bus.i_data = '0;
    #12;
    chk_status("reset_status", 3'd0, 1'b0);
    n_vec++;
    if (bus.o_data !== '0 || bus.o_overflow !== 1'b0 || bus.o_wready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_outputs: data0=%0d ovf=%b wready=%b, required 0 0 1",
               bus.o_data[0], bus.o_overflow, bus.o_wready);
    end
    @(negedge clk); rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_write();
    write_blocks(1, 1);
    chk_status("single_after_write", 3'd1, 1'b0);
    step();
    chk_status("single_fwft", 3'd1, 1'b1);
    n_vec++;
    if (bus.o_data !== mk(1)) begin
      n_err++;
      $display("FAIL single_data: data[0]=%0d data[9]=%0d, required 1 10", bus.o_data[0], bus.o_data[9]);
    end
    bus.i_rready = 1'b1;
    step();
    bus.i_rready = 1'b0;
    chk_status("single_consumed", 3'd0, 1'b0);
  endtask

  task automatic test_fill_overflow();
    write_blocks(100, 4);
    chk_status("fill_full", 3'd4, 1'b1);
    n_vec++;
    if (bus.o_wready !== 1'b0 || bus.o_overflow !== 1'b0) begin
      n_err++;
      $display("FAIL fill_wready: wready=%b ovf=%b, required 0 0", bus.o_wready, bus.o_overflow);
    end
    bus.i_data = mk(900); bus.i_wvalid = 1'b1;
    step();
    bus.i_wvalid = 1'b0;
    n_vec++;
    if (bus.o_overflow !== 1'b1 || bus.o_count !== 3'd4) begin
      n_err++;
      $display("FAIL overflow_pulse: ovf=%b count=%0d, required 1 4", bus.o_overflow, bus.o_count);
    end
    step();
    n_vec++;
    if (bus.o_overflow !== 1'b0) begin
      n_err++;
      $display("FAIL overflow_clear: ovf=%b, required 0", bus.o_overflow);
    end
    drain("fill_drain", 100, 4);
    chk_status("fill_empty", 3'd0, 1'b0);
  endtask

  task automatic test_wrap();
    blk_t exp_q[$];
    logic [6:0] wpat = 7'b1011011;
    logic [6:0] rpat = 7'b0110101;
    int wcnt = 0, rcnt = 0, cyc = 0;
    logic wx, rx;
    while (rcnt < 10 && cyc < 200) begin
      bus.i_wvalid = (wcnt < 10) && wpat[cyc % 7];
      bus.i_data   = mk(2000 + 16 * wcnt);
      bus.i_rready = rpat[cyc % 7];
      #1;
      wx = bus.i_wvalid & bus.o_wready;
      rx = bus.o_rvalid & bus.i_rready;
      if (rx) begin
        n_vec++;
        if (exp_q.size() == 0 || bus.o_data !== exp_q[0]) begin
          n_err++;
          $display("FAIL wrap_order[%0d]: data[0]=%0d, required %0d", rcnt, bus.o_data[0],
                   (exp_q.size() == 0) ? -1 : int'(exp_q[0][0]));
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        rcnt++;
      end
      if (wx) begin
        exp_q.push_back(bus.i_data);
        wcnt++;
      end
      cyc++;
      step();
    end
    bus.i_wvalid = 1'b0; bus.i_rready = 1'b0;
    n_vec++;
    if (rcnt != 10 || wcnt != 10) begin
      n_err++;
      $display("FAIL wrap_budget: reads=%0d writes=%0d, required 10 10", rcnt, wcnt);
    end
    chk_status("wrap_empty", 3'd0, 1'b0);
  endtask

  task automatic test_simultaneous();
    write_blocks(3000, 2);
    step();
    chk_status("simul_two", 3'd2, 1'b1);
    bus.i_data = mk(3032); bus.i_wvalid = 1'b1; bus.i_rready = 1'b1;
    n_vec++;
    if (bus.o_data !== mk(3000)) begin
      n_err++;
      $display("FAIL simul_head: data[0]=%0d, required 3000", bus.o_data[0]);
    end
    step();
    bus.i_wvalid = 1'b0; bus.i_rready = 1'b0;
    chk_status("simul_count_kept", 3'd2, 1'b1);
    drain("simul_order", 3016, 2);
    write_blocks(4000, 4);
    bus.i_data = mk(4064); bus.i_wvalid = 1'b1; bus.i_rready = 1'b1;
    n_vec++;
    if (bus.o_wready !== 1'b0) begin
      n_err++;
      $display("FAIL full_no_writethrough: wready=%b, required 0", bus.o_wready);
    end
    step();
    bus.i_wvalid = 1'b0; bus.i_rready = 1'b0;
    chk_status("full_rw_count", 3'd3, 1'b1);
    drain("full_rw_order", 4016, 3);
    chk_status("full_rw_empty", 3'd0, 1'b0);
  endtask

  task automatic test_flush();
    write_blocks(5000, 3);
    step();
    chk_status("flush_pre", 3'd3, 1'b1);
    bus.i_data = mk(5555); bus.i_wvalid = 1'b1; bus.i_rready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; bus.i_wvalid = 1'b0; bus.i_rready = 1'b0;
    chk_status("flush_clear", 3'd0, 1'b0);
    write_blocks(6000, 1);
    step();
    chk_status("flush_rewrite", 3'd1, 1'b1);
    drain("flush_readback", 6000, 1);
    chk_status("flush_final", 3'd0, 1'b0);
  endtask

  task automatic test_enable_reset();
    write_blocks(7000, 2);
    step();
    en = 1'b0;
    bus.i_data = mk(7777); bus.i_wvalid = 1'b1; bus.i_rready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      n_vec++;
      if (bus.o_wready !== 1'b0 || bus.o_rvalid !== 1'b0 || bus.o_count !== 3'd2 ||
          bus.o_data !== mk(7000)) begin
        n_err++;
        $display("FAIL enable_freeze[%0d]: wready=%b rvalid=%b count=%0d data[0]=%0d, required 0 0 2 7000",
                 k, bus.o_wready, bus.o_rvalid, bus.o_count, bus.o_data[0]);
      end
    end
    bus.i_wvalid = 1'b0; bus.i_rready = 1'b0;
    en = 1'b1;
    #1;
    chk_status("enable_resume", 3'd2, 1'b1);
    bus.i_wvalid = 1'b1; bus.i_rready = 1'b1;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_status("async_reset", 3'd0, 1'b0);
    n_vec++;
    if (bus.o_data !== '0 || bus.o_overflow !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset_data: data0=%0d ovf=%b, required 0 0", bus.o_data[0], bus.o_overflow);
    end
    bus.i_wvalid = 1'b0; bus.i_rready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    write_blocks(8000, 1);
    step();
    drain("post_reset", 8000, 1);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fill_overflow();
    test_wrap();
    test_simultaneous();
    test_flush();
    test_enable_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
